// File: rtl/datapath_pkg.sv
// Shared types and helpers for the parametrised datapath core.
//   op_e     : ALU opcode encoding (3 bits, MUL is the only multi-cycle op)
//   state_e  : multiply sequencer states
//   lane_of  : extracts one DW-bit lane from a zero-extended input bus;
//              a lane index past the last lane yields zero.
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SHR = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_MOV = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Widest NLANES*DW input bus the helper can carry.
  localparam int unsigned LANE_BUS_MAX = 4096;

  function automatic logic [LANE_BUS_MAX-1:0] lane_of(
    input logic [LANE_BUS_MAX-1:0] in_port,
    input int unsigned             sel,
    input int unsigned             dw,
    input int unsigned             nlanes
  );
    logic [LANE_BUS_MAX-1:0] mask;
    logic [LANE_BUS_MAX-1:0] result;
    mask = ~({LANE_BUS_MAX{1'b1}} << dw);
    if (sel >= nlanes) result = '0;
    else               result = (in_port >> (sel * dw)) & mask;
    return result;
  endfunction

endpackage

// File: rtl/datapath_regfile.sv
// Register bank for the datapath core: NREGS x DW, one write port, two
// asynchronous read ports, synchronous active-high clear.
// Configuration macro DATAPATH_BYPASS_EN: when defined, a read of the address
// being written in the same cycle returns the incoming write data; otherwise
// the read returns the stored (old) value.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_wen/i_wa/i_wdata write enable, address, data
//   i_raa/i_rab       read addresses for operands A and B
//   o_rda/o_rdb       read data for operands A and B
module datapath_regfile #(
  parameter int DW    = 8,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wen,
  input  logic [$clog2(NREGS)-1:0] i_wa,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raa,
  input  logic [$clog2(NREGS)-1:0] i_rab,
  output logic [DW-1:0]            o_rda,
  output logic [DW-1:0]            o_rdb
);

  logic [DW-1:0] r_mem [NREGS];

  // NOTE: clearing every entry on reset keeps this as flops rather than a RAM
  // macro; the bank is small and must read as zero right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_wen) begin
      r_mem[i_wa] <= i_wdata;
    end
  end

`ifdef DATAPATH_BYPASS_EN
  assign o_rda = (i_wen && (i_raa == i_wa)) ? i_wdata : r_mem[i_raa];
  assign o_rdb = (i_wen && (i_rab == i_wa)) ? i_wdata : r_mem[i_rab];
`else
  assign o_rda = r_mem[i_raa];
  assign o_rdb = r_mem[i_rab];
`endif

endmodule

// File: rtl/datapath_core_param.sv
// Parametrised datapath core: a register bank loaded from one selectable lane
// of a wide input port, and an ALU reading two registers into a registered
// OutPort / Flag. MUL is an iterative shift-add taking DW cycles, during which
// Busy is high and Op/RAA/RAB/Wen are ignored.
// Configuration macro DATAPATH_BYPASS_EN (see datapath_regfile) enables the
// same-cycle write-to-read bypass.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   InPort    NLANES lanes of DW bits; lane k = InPort[k*DW +: DW]
//   Sel       lane written on Wen (out-of-range lane writes 0)
//   Wen, WA   register write enable / address
//   RAA, RAB  operand read addresses
//   Op        ALU opcode (op_e)
//   OutPort   registered result, low OW bits
//   Flag      registered: full DW-bit result is zero
//   Busy      multiply in progress
module datapath_core_param
  import datapath_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NLANES = 8,
  parameter int NREGS  = 16,
  parameter int OW     = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NLANES*DW-1:0]      InPort,
  input  logic [$clog2(NLANES)-1:0] Sel,
  input  logic                      Wen,
  input  logic [$clog2(NREGS)-1:0]  WA,
  input  logic [$clog2(NREGS)-1:0]  RAA,
  input  logic [$clog2(NREGS)-1:0]  RAB,
  input  logic [2:0]                Op,
  output logic [OW-1:0]             OutPort,
  output logic                      Flag,
  output logic                      Busy
);

  localparam int CW = $clog2(DW + 1);

  state_e          r_state, w_state_nx;
  logic [DW-1:0]   r_acc, w_acc_nx;
  logic [DW-1:0]   r_mcand, w_mcand_nx;
  logic [DW-1:0]   r_mplier, w_mplier_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [OW-1:0]   r_out, w_out_nx;
  logic            r_flag, w_flag_nx;

  logic [DW-1:0]   w_lane;
  logic [DW-1:0]   w_a, w_b;
  logic [DW-1:0]   w_alu;
  logic [DW-1:0]   w_acc_sum;
  logic            w_wen;

  always_comb begin
    w_lane = DW'(lane_of(LANE_BUS_MAX'(InPort), 32'(Sel), DW, NLANES));
  end

  // Writes are dropped while the multiplier owns the datapath.
  assign w_wen = Wen && (r_state == ST_IDLE);

  datapath_regfile #(
    .DW    (DW),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_wen   (w_wen),
    .i_wa    (WA),
    .i_wdata (w_lane),
    .i_raa   (RAA),
    .i_rab   (RAB),
    .o_rda   (w_a),
    .o_rdb   (w_b)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_alu = '0;
    unique case (op_e'(Op))
      OP_ADD: w_alu = w_a + w_b;
      OP_SHR: w_alu = w_a >> 1;
      OP_SUB: w_alu = w_a - w_b;
      OP_AND: w_alu = w_a & w_b;
      OP_MOV: w_alu = w_a;
      OP_OR:  w_alu = w_a | w_b;
      OP_XOR: w_alu = w_a ^ w_b;
      OP_MUL: w_alu = '0;
      default: w_alu = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set. Truncation to DW bits gives the low product bits.
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_state_nx  = r_state;
    w_acc_nx    = r_acc;
    w_mcand_nx  = r_mcand;
    w_mplier_nx = r_mplier;
    w_cnt_nx    = r_cnt;
    w_out_nx    = r_out;
    w_flag_nx   = r_flag;
    unique case (r_state)
      ST_IDLE: begin
        if (op_e'(Op) == OP_MUL) begin
          w_state_nx  = ST_RUN;
          w_acc_nx    = '0;
          w_mcand_nx  = w_a;
          w_mplier_nx = w_b;
          w_cnt_nx    = CW'(DW);
        end else begin
          w_out_nx  = w_alu[OW-1:0];
          w_flag_nx = (w_alu == '0);
        end
      end
      ST_RUN: begin
        w_acc_nx    = w_acc_sum;
        w_mcand_nx  = r_mcand << 1;
        w_mplier_nx = r_mplier >> 1;
        w_cnt_nx    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nx = ST_IDLE;
          w_out_nx   = w_acc_sum[OW-1:0];
          w_flag_nx  = (w_acc_sum == '0);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_acc    <= w_acc_nx;
      r_mcand  <= w_mcand_nx;
      r_mplier <= w_mplier_nx;
      r_cnt    <= w_cnt_nx;
      r_out    <= w_out_nx;
      r_flag   <= w_flag_nx;
    end
  end

  assign OutPort = r_out;
  assign Flag    = r_flag;
  assign Busy    = (r_state == ST_RUN);

endmodule
